// File: rtl/core_pkg.sv
// Shared scoreboard definitions: register address width, default sizing and FSM states.
package core_pkg;

    localparam int unsigned REG_ADDR_W    = 3;
    localparam int unsigned ADDR_SPACE    = 1 << REG_ADDR_W;
    localparam int unsigned NUM_REGS_DEF  = 8;
    localparam int unsigned MAX_LOADS_DEF = 2;
    localparam int unsigned LOAD_CNT_W    = 3;
    localparam int unsigned STALL_CNT_W   = 16;

    typedef enum logic {
        SB_RUN   = 1'b0,
        SB_DRAIN = 1'b1
    } sb_state_e;

endpackage

// File: rtl/sb_hazard_check.sv
// Combinational RAW / WAW / load-limit detection against the registered scoreboard state.
module sb_hazard_check
    import core_pkg::*;
#(
    parameter int unsigned NUM_REGS  = NUM_REGS_DEF,
    parameter int unsigned MAX_LOADS = MAX_LOADS_DEF
) (
    input  logic [NUM_REGS-1:0]   pending_i,
    input  logic [LOAD_CNT_W-1:0] load_cnt_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  we_i,
    input  logic                  is_load_i,
    output logic                  raw_o,
    output logic                  waw_o,
    output logic                  load_limit_o
);

    logic [ADDR_SPACE-1:0] w_pend_ext;
    logic                  w_rs1_nz;
    logic                  w_rs2_nz;
    logic                  w_rd_nz;

    // Widen to the full address space so any 3-bit address indexes safely.
    assign w_pend_ext = ADDR_SPACE'(pending_i);

    assign w_rs1_nz = (rs1_addr_i != '0);
    assign w_rs2_nz = (rs2_addr_i != '0);
    assign w_rd_nz  = (rd_addr_i != '0);

    assign raw_o = (w_rs1_nz && w_pend_ext[rs1_addr_i]) ||
                   (w_rs2_nz && w_pend_ext[rs2_addr_i]);

    assign waw_o = we_i && w_rd_nz && w_pend_ext[rd_addr_i];

    assign load_limit_o = is_load_i && we_i && w_rd_nz &&
                          (load_cnt_i == LOAD_CNT_W'(MAX_LOADS));

endmodule

// File: rtl/scoreboard_ctrl.sv
// In-order issue scoreboard tracking outstanding load destinations, with fence drain.
// Optional stall cycle counter output enabled by defining SB_PERF_CNT_EN.
module scoreboard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned NUM_REGS  = NUM_REGS_DEF,
    parameter int unsigned MAX_LOADS = MAX_LOADS_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic [REG_ADDR_W-1:0] issue_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] issue_rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_addr_i,
    input  logic                  issue_we_i,
    input  logic                  issue_is_load_i,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
    input  logic                  fence_i,
    output logic                  fence_done_o,
    output logic                  stall_o,
    output logic [NUM_REGS-1:0]   busy_mask_o
`ifdef SB_PERF_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
`endif
);

    sb_state_e             r_state;
    sb_state_e             w_state_nxt;
    logic [NUM_REGS-1:0]   r_pending;
    logic [NUM_REGS-1:0]   w_pending_nxt;
    logic [LOAD_CNT_W-1:0] r_load_cnt;
    logic [LOAD_CNT_W-1:0] w_load_cnt_nxt;

    logic                  w_raw;
    logic                  w_waw;
    logic                  w_load_limit;
    logic                  w_accept;
    logic                  w_track_load;
    logic                  w_wb_hit;
    logic                  w_empty;
    logic [NUM_REGS-1:0]   w_rd_mask;
    logic [NUM_REGS-1:0]   w_wb_mask;

    sb_hazard_check #(
        .NUM_REGS  (NUM_REGS),
        .MAX_LOADS (MAX_LOADS)
    ) u_hazard (
        .pending_i    (r_pending),
        .load_cnt_i   (r_load_cnt),
        .rs1_addr_i   (issue_rs1_addr_i),
        .rs2_addr_i   (issue_rs2_addr_i),
        .rd_addr_i    (issue_rd_addr_i),
        .we_i         (issue_we_i),
        .is_load_i    (issue_is_load_i),
        .raw_o        (w_raw),
        .waw_o        (w_waw),
        .load_limit_o (w_load_limit)
    );

    assign issue_ready_o = (r_state == SB_RUN) && !w_raw && !w_waw && !w_load_limit;
    assign stall_o       = issue_valid_i && !issue_ready_o;
    assign w_accept      = issue_valid_i && issue_ready_o;

    // Register 0 is never tracked, so its bit is masked out of both decodes.
    assign w_rd_mask = NUM_REGS'(ADDR_SPACE'(1) << issue_rd_addr_i) & ~NUM_REGS'(1);
    assign w_wb_mask = NUM_REGS'(ADDR_SPACE'(1) << wb_rd_addr_i) & ~NUM_REGS'(1);

    assign w_track_load = w_accept && issue_is_load_i && issue_we_i && (|w_rd_mask);
    assign w_wb_hit     = wb_valid_i && (|(r_pending & w_wb_mask));
    assign w_empty      = (r_pending == '0) && (r_load_cnt == '0);

    assign busy_mask_o = r_pending & ~NUM_REGS'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= SB_RUN;
            r_pending  <= '0;
            r_load_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_load_cnt <= w_load_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pending_nxt  = r_pending;
        w_load_cnt_nxt = r_load_cnt;
        fence_done_o   = 1'b0;

        case (r_state)
            SB_RUN: begin
                if (fence_i) begin
                    w_state_nxt = SB_DRAIN;
                end
            end
            SB_DRAIN: begin
                if (w_empty) begin
                    fence_done_o = 1'b1;
                    w_state_nxt  = SB_RUN;
                end
            end
            default: begin
                w_state_nxt = SB_RUN;
            end
        endcase

        // Issue and writeback never target the same register (WAW blocks it).
        if (w_track_load) begin
            w_pending_nxt = w_pending_nxt | w_rd_mask;
        end
        if (w_wb_hit) begin
            w_pending_nxt = w_pending_nxt & ~w_wb_mask;
        end

        case ({w_track_load, w_wb_hit})
            2'b10:   w_load_cnt_nxt = r_load_cnt + LOAD_CNT_W'(1);
            2'b01:   w_load_cnt_nxt = r_load_cnt - LOAD_CNT_W'(1);
            default: w_load_cnt_nxt = r_load_cnt;
        endcase
    end

`ifdef SB_PERF_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Saturating count of stalled issue cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if (stall_o && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: doc/scoreboard_ctrl.md
SCOREBOARD_CTRL -- requirements
Module: scoreboard_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, number of architectural registers (3-bit addresses).
REQ-002 SHALL have parameter MAX_LOADS, default 2, maximum outstanding tracked loads (1..7).
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk_i input 1, rising-edge clock; rst_ni input 1, reset.
REQ-004 SHALL have issue_valid_i input 1, decode presents an instruction.
REQ-005 SHALL have issue_ready_o output 1, scoreboard accepts the instruction this cycle.
REQ-006 SHALL have issue_rs1_addr_i, issue_rs2_addr_i, issue_rd_addr_i inputs 3, source and destination addresses.
REQ-007 SHALL have issue_we_i input 1, instruction writes rd; issue_is_load_i input 1, instruction is a load.
REQ-008 SHALL have wb_valid_i input 1 and wb_rd_addr_i input 3, load writeback returning from memory.
REQ-009 SHALL have fence_i input 1, drain request; fence_done_o output 1, drain complete pulse.
REQ-010 SHALL have stall_o output 1, and busy_mask_o output NUM_REGS, registered pending-load bits.

Function
REQ-011 SHALL hold state RUN or DRAIN, plus pending[NUM_REGS] and load_cnt (3 bits).
REQ-012 SHALL treat an issue as accepted iff issue_valid_i && issue_ready_o in the same cycle.
REQ-013 SHALL drive issue_ready_o = (state==RUN) && no RAW && no WAW && no load-limit, all from registered state only.
REQ-014 SHALL flag RAW when rs1 or rs2 is nonzero and its pending bit is set; address 0 never hazards.
REQ-015 SHALL flag WAW when issue_we_i, rd nonzero, pending[rd] set.
REQ-016 SHALL flag load-limit when issue_is_load_i, issue_we_i, rd nonzero, load_cnt==MAX_LOADS.
REQ-017 SHALL, on an accepted load with issue_we_i and nonzero rd, set pending[rd] and increment load_cnt at the next edge.
REQ-018 SHALL treat a load with rd==0 or !issue_we_i as untracked: no pending bit, no count change.
REQ-019 SHALL, on wb_valid_i with pending[wb_rd_addr_i] set, clear that bit and decrement load_cnt; otherwise ignore the writeback.
REQ-020 SHALL, on simultaneous accepted load and valid writeback (different registers by REQ-015), apply both; load_cnt unchanged net.
REQ-021 SHALL drive stall_o = issue_valid_i && !issue_ready_o.
REQ-022 SHALL move RUN->DRAIN on fence_i in RUN; an issue accepted in that same cycle still updates state.
REQ-023 SHALL ignore fence_i while in DRAIN.
REQ-024 SHALL in DRAIN drive fence_done_o=1 for exactly the cycle where pending==0 and load_cnt==0, and move to RUN at that edge.
REQ-025 SHALL therefore assert fence_done_o no earlier than one cycle after fence_i, even when already empty.
REQ-026 SHALL drive busy_mask_o directly from pending; bit 0 is always 0.

Reset
REQ-027 SHALL, on rst_ni low (asynchronous, any state), set state=RUN, pending=0, load_cnt=0.
REQ-028 SHALL hold issue_ready_o=1, stall_o=0, fence_done_o=0, busy_mask_o=0 during and after reset until stimulus.
REQ-029 SHALL drop in-flight tracking on mid-drain reset; no fence_done_o pulse is issued for the aborted fence.

Configuration
REQ-030 SHALL, with SB_PERF_CNT_EN defined, add output stall_cnt_o (16 bits) counting cycles with stall_o=1, saturating at 16'hFFFF, reset to 0.
REQ-031 SHALL, without SB_PERF_CNT_EN, omit stall_cnt_o and its counter entirely.

Structure
REQ-032 SHALL place the state enum (SB_RUN, SB_DRAIN), REG_ADDR_W=3 and the default NUM_REGS/MAX_LOADS constants in shared package core_pkg.
REQ-033 SHALL implement hazard detection (REQ-014..016) in a combinational sub-module sb_hazard_check; state and counters stay in scoreboard_ctrl.

Verification
REQ-034 SHALL cover: load rd=3 accepted; next cycle rs1=3 -> stall_o=1, busy_mask_o=8'h08; wb rd=3 -> issue accepted next cycle.
REQ-035 SHALL cover: loads to rd=1,2 accepted; third load rd=4 -> issue_ready_o=0 (load_cnt=2); wb rd=1 -> rd=4 accepted the following cycle.
REQ-036 SHALL cover: rs1=0, rs2=0, rd=0 with busy_mask_o=8'hFE -> issue_ready_o=1; load rd=0 accepted -> load_cnt stays 0.
REQ-037 SHALL cover: same-cycle load rd=5 accept and wb rd=2 -> busy_mask_o changes 8'h04->8'h20, load_cnt stays 1.
REQ-038 SHALL cover: fence_i with two loads pending -> issue_ready_o=0 until both wb; fence_done_o one cycle after last wb, then RUN.
REQ-039 SHALL cover: rst_ni low mid-DRAIN with busy_mask_o=8'h06 -> immediately busy_mask_o=0, issue_ready_o=1, no fence_done_o.
